// File: rtl/fp_mul_arb_pkg.sv
// rtl/fp_mul_arb_pkg.sv - shared types and constants for the fp multiplier arbiter
// Sequencer state encoding plus IEEE-754 single constants used around the arbiter.
package fp_mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_Z,
    DELIVER
  } arb_state_e;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_HALF = 32'h3f00_0000;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
// Returns the first set request at or above ptr_i, wrapping around to index 0.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           valid_o
);

  int k;

  // Walk the rotation backwards so the last hit written is the nearest to ptr_i.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = IDW'(k);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin arbiter sharing one fp multiplier
// One multiply in flight: grant, issue operands, wait for product, deliver result.
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = FP_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        req_stb_i,
  input  logic [NREQ-1:0][W-1:0] req_a_i,
  input  logic [NREQ-1:0][W-1:0] req_b_i,
  output logic [NREQ-1:0]        req_ack_o,
  output logic [W-1:0]           res_z_o,
  output logic [NREQ-1:0]        res_stb_o,
  input  logic [NREQ-1:0]        res_ack_i,
  output logic [W-1:0]           mul_a_o,
  output logic [W-1:0]           mul_b_o,
  output logic                   mul_a_stb_o,
  output logic                   mul_b_stb_o,
  input  logic                   mul_a_ack_i,
  input  logic                   mul_b_ack_i,
  input  logic [W-1:0]           mul_z_i,
  input  logic                   mul_z_stb_i,
  output logic                   mul_z_ack_o,
  output logic                   busy_o,
  output logic [IDW-1:0]         grant_id_o
);

  arb_state_e      state_q;
  logic [W-1:0]    a_q, b_q, res_z_q;
  logic [NREQ-1:0] req_ack_q, res_stb_q;
  logic            mul_a_stb_q, mul_b_stb_q, mul_z_ack_q;
  logic [IDW-1:0]  grant_q, ptr_q, ptr_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_valid;
  logic            a_done, b_done;

  rr_pick #(.N(NREQ), .IDW(IDW)) u_pick (
    .req_i   (req_stb_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign ptr_d  = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
  assign a_done = !mul_a_stb_q || mul_a_ack_i;
  assign b_done = !mul_b_stb_q || mul_b_ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_z_q     <= '0;
      req_ack_q   <= '0;
      res_stb_q   <= '0;
      mul_a_stb_q <= 1'b0;
      mul_b_stb_q <= 1'b0;
      mul_z_ack_q <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= '0;
    end else begin
      req_ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            req_ack_q   <= pick_gnt;
            a_q         <= req_a_i[pick_idx];
            b_q         <= req_b_i[pick_idx];
            grant_q     <= pick_idx;
            ptr_q       <= ptr_d;
            mul_a_stb_q <= 1'b1;
            mul_b_stb_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // The two operand ports complete independently and may ack in any order.
          if (mul_a_ack_i) mul_a_stb_q <= 1'b0;
          if (mul_b_ack_i) mul_b_stb_q <= 1'b0;
          if (a_done && b_done) begin
            mul_z_ack_q <= 1'b1;
            state_q     <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (mul_z_stb_i) begin
            res_z_q     <= mul_z_i;
            mul_z_ack_q <= 1'b0;
            res_stb_q   <= NREQ'(1) << grant_q;
            state_q     <= DELIVER;
          end
        end
        DELIVER: begin
          if (res_ack_i[grant_q]) begin
            res_stb_q <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack_o   = req_ack_q;
  assign res_z_o     = res_z_q;
  assign res_stb_o   = res_stb_q;
  assign mul_a_o     = a_q;
  assign mul_b_o     = b_q;
  assign mul_a_stb_o = mul_a_stb_q;
  assign mul_b_stb_o = mul_b_stb_q;
  assign mul_z_ack_o = mul_z_ack_q;
  assign busy_o      = (state_q != IDLE);
  assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - self-checking bench for fp_mul_arbiter
// Requester agents, a multiplier responder and a round-robin reference run on the falling edge.
module tb_fp_mul_arbiter;
  import fp_mul_arb_pkg::*;

  localparam int N  = 4;
  localparam int QD = 128;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]       req_stb, req_ack, res_stb, res_ack;
  logic [N-1:0][31:0] req_a, req_b;
  logic [31:0]        res_z, mul_a, mul_b, mul_z;
  logic               mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack, busy;
  logic [1:0]         grant_id;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NREQ(N), .W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_stb_i(req_stb), .req_a_i(req_a), .req_b_i(req_b), .req_ack_o(req_ack),
    .res_z_o(res_z), .res_stb_o(res_stb), .res_ack_i(res_ack),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_a_stb_o(mul_a_stb), .mul_b_stb_o(mul_b_stb),
    .mul_a_ack_i(mul_a_ack), .mul_b_ack_i(mul_b_ack),
    .mul_z_i(mul_z), .mul_z_stb_i(mul_z_stb), .mul_z_ack_o(mul_z_ack),
    .busy_o(busy), .grant_id_o(grant_id)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference single-precision multiply for normal operands (zero in, signed zero out).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    int e;
    logic s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      e++;
      m = m >> 1;
    end
    return {s, 8'(e), m[45:23]};
  endfunction

  logic [31:0] qa [N][QD];
  logic [31:0] qb [N][QD];
  int qh[N], qt[N], rstate[N], stall_cfg[N], stall_cnt[N], stall_used[N];
  bit drop_req[N], done_res[N];
  bit spurious;

  int m_ptr, m_g, n_done, cyc, res_hold, split_cnt;
  bit in_flight;
  logic [31:0] m_a, m_b;
  int glog[$], gtick[$], rtick[$];
  logic [31:0] rlog[$], rstblog[$];

  int a_dly, b_dly, lat, a_wait, b_wait, z_wait, na, nb;
  bit got_a, got_b, zon, zx;
  logic [31:0] opa, opb;

  task automatic push_req(input int i, input logic [31:0] a, input logic [31:0] b);
    qa[i][qt[i]] = a;
    qb[i][qt[i]] = b;
    qt[i]++;
  endtask

  task automatic tick();
    cyc++;
    if (!rst_n) begin
      req_stb = '0; req_a = '0; req_b = '0; res_ack = '0;
      mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z = '0; mul_z_stb = 1'b0;
      for (int i = 0; i < N; i++) begin
        qh[i] = 0; qt[i] = 0; rstate[i] = 0; drop_req[i] = 0; done_res[i] = 0;
      end
      m_ptr = 0; in_flight = 0; got_a = 0; got_b = 0; zon = 0; zx = 0; res_hold = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (drop_req[i]) begin
        req_stb[i] = 1'b0; drop_req[i] = 0; qh[i]++; rstate[i] = 2;
      end
      if (done_res[i]) begin
        res_ack[i] = 1'b0; done_res[i] = 0; rstate[i] = 0; in_flight = 0; n_done++;
      end
    end
    if (req_ack != '0) begin
      int g;
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req_stb[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      expect_eq("grant_while_busy", 32'(in_flight), 32'd0);
      if (g < 0) expect_eq("req_ack_spurious", 32'(req_ack), 32'd0);
      else begin
        expect_eq("req_ack", 32'(req_ack), 32'(1 << g));
        expect_eq("grant_id", 32'(grant_id), 32'(g));
        in_flight = 1; m_g = g; m_a = req_a[g]; m_b = req_b[g]; m_ptr = (g + 1) % N;
        glog.push_back(g); gtick.push_back(cyc);
        na = 0; nb = 0; res_hold = 0; a_wait = a_dly; b_wait = b_dly; z_wait = lat;
      end
      for (int i = 0; i < N; i++) if (req_ack[i] && req_stb[i]) drop_req[i] = 1;
    end
    expect_eq("busy", 32'(busy), 32'(in_flight));
    if (res_stb != '0) begin
      res_hold++;
      expect_eq("res_stb", 32'(res_stb), in_flight ? 32'(1 << m_g) : 32'd0);
      expect_eq("res_z", res_z, fmul(m_a, m_b));
    end
    for (int i = 0; i < N; i++) begin
      if (rstate[i] == 2 && res_stb[i]) begin
        if (stall_cnt[i] > 0) begin
          stall_cnt[i]--; res_ack[i] = 1'b0;
        end else begin
          res_ack[i] = 1'b1; done_res[i] = 1;
          expect_eq("mul_a_xfers", 32'(na), 32'd1);
          expect_eq("mul_b_xfers", 32'(nb), 32'd1);
          expect_eq("res_hold", 32'(res_hold), 32'(stall_used[i] + 1));
          rlog.push_back(res_z); rstblog.push_back(32'(res_stb)); rtick.push_back(cyc);
        end
      end else if (rstate[i] != 2) res_ack[i] = spurious ? 1'($urandom) : 1'b0;
      else res_ack[i] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (rstate[i] == 0 && qt[i] > qh[i]) begin
        req_stb[i] = 1'b1; req_a[i] = qa[i][qh[i]]; req_b[i] = qb[i][qh[i]];
        rstate[i] = 1; stall_cnt[i] = stall_cfg[i]; stall_used[i] = stall_cfg[i];
      end
    end
    if (zx) begin
      mul_z_stb = 1'b0; zon = 0; got_a = 0; got_b = 0; zx = 0;
    end
    if (got_a) expect_eq("mul_a_stb_drop", 32'(mul_a_stb), 32'd0);
    if (got_b) expect_eq("mul_b_stb_drop", 32'(mul_b_stb), 32'd0);
    mul_a_ack = 1'b0;
    mul_b_ack = 1'b0;
    if (mul_a_stb && !got_a) begin
      if (a_wait > 0) a_wait--;
      else begin
        mul_a_ack = 1'b1; got_a = 1; na++; opa = mul_a;
        expect_eq("mul_a", mul_a, m_a);
      end
    end
    if (mul_b_stb && !got_b) begin
      if (b_wait > 0) b_wait--;
      else begin
        mul_b_ack = 1'b1; got_b = 1; nb++; opb = mul_b;
        expect_eq("mul_b", mul_b, m_b);
      end
    end
    if (mul_b_stb && !mul_a_stb) split_cnt++;
    if (got_a && got_b && !zon) begin
      if (z_wait > 0) z_wait--;
      else begin
        mul_z = fmul(opa, opb); mul_z_stb = 1'b1; zon = 1;
      end
    end
    if (mul_z_stb && mul_z_ack) zx = 1;
  endtask

  initial forever begin
    @(negedge clk);
    tick();
  end

  task automatic check_reset_outputs();
    expect_eq("rst_req_ack", 32'(req_ack), 32'd0);
    expect_eq("rst_res_stb", 32'(res_stb), 32'd0);
    expect_eq("rst_res_z", res_z, FP_ZERO);
    expect_eq("rst_mul_a", mul_a, 32'd0);
    expect_eq("rst_mul_b", mul_b, 32'd0);
    expect_eq("rst_ctrl", 32'({mul_a_stb, mul_b_stb, mul_z_ack, busy}), 32'd0);
    expect_eq("rst_grant_id", 32'(grant_id), 32'd0);
  endtask

  task automatic clear_logs();
    glog.delete(); gtick.delete(); rtick.delete(); rlog.delete(); rstblog.delete();
    n_done = 0; split_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_done(input int target, input int budget);
    int c;
    c = 0;
    while (n_done < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1 expect_eq("done_count", 32'(n_done), 32'(target));
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    req_stb = '0; req_a = '0; req_b = '0; res_ack = '0;
    mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z = '0; mul_z_stb = 1'b0;
    spurious = 0; a_dly = 0; b_dly = 0; lat = 2; cyc = 0;
    for (int i = 0; i < N; i++) stall_cfg[i] = 0;
    clear_logs();
    #1 check_reset_outputs();
    do_reset();

    push_req(0, FP_HALF, 32'h3f80_0000);
    wait_done(1, 200);
    expect_eq("single_grant", 32'(glog[0]), 32'd0);
    expect_eq("single_res_z", rlog[0], FP_HALF);
    expect_eq("single_res_stb", rstblog[0], 32'h1);

    do_reset();
    push_req(0, FP_HALF, FP_ZERO);
    push_req(1, FP_HALF, 32'hbf00_0000);
    push_req(2, FP_HALF, 32'h3f80_0000);
    wait_done(3, 300);
    for (int k = 0; k < 3; k++) expect_eq("three_order", 32'(glog[k]), 32'(k));
    expect_eq("three_res0", rlog[0], 32'h0000_0000);
    expect_eq("three_res1", rlog[1], 32'hbe80_0000);
    expect_eq("three_res2", rlog[2], 32'h3f00_0000);

    clear_logs();
    a_dly = 0; b_dly = 3;
    push_req(2, 32'h4040_0000, 32'h3fc0_0000);
    wait_done(1, 200);
    expect_eq("split_cycles", 32'(split_cnt), 32'd3);
    b_dly = 0;

    clear_logs();
    stall_cfg[1] = 10;
    push_req(1, 32'h4000_0000, 32'hc040_0000);
    c = 0;
    while (!busy && c < 50) begin @(posedge clk); #1 c++; end
    push_req(3, FP_HALF, FP_HALF);
    wait_done(2, 300);
    stall_cfg[1] = 0;
    expect_eq("stall_order0", 32'(glog[0]), 32'd1);
    expect_eq("stall_order1", 32'(glog[1]), 32'd3);
    expect_eq("stall_gap", 32'(gtick[1] - rtick[0]), 32'd2);

    clear_logs();
    lat = 20;
    push_req(1, 32'h4080_0000, FP_HALF);
    c = 0;
    while (!mul_z_ack && c < 100) begin @(posedge clk); #1 c++; end
    expect_eq("reach_wait_z", 32'(mul_z_ack), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    lat = 2;
    #1 check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    push_req(2, FP_HALF, 32'h4100_0000);
    push_req(1, FP_HALF, 32'h4200_0000);
    wait_done(2, 300);
    expect_eq("post_rst_first", 32'(glog[0]), 32'd1);
    expect_eq("post_rst_second", 32'(glog[1]), 32'd2);
    expect_eq("post_rst_res", rlog[1], 32'h4080_0000);

    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_req(0, 32'(32'h3f80_0000 + (k << 20)), FP_HALF);
      push_req(3, 32'(32'h4000_0000 + (k << 20)), FP_HALF);
    end
    wait_done(8, 600);
    for (int k = 0; k < 8; k++) expect_eq("fair_order", 32'(glog[k]), (k % 2 == 1) ? 32'd3 : 32'd0);

    clear_logs();
    spurious = 1;
    for (int k = 0; k < 40; k++) begin
      int i;
      i = $urandom_range(0, N - 1);
      push_req(i, {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)},
                  {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)});
      stall_cfg[i] = $urandom_range(0, 3);
      a_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3);
      lat   = $urandom_range(0, 5);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 12)) @(posedge clk);
    end
    wait_done(40, 4000);
    spurious = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
